mem_wb_stage: RTL and testbench

- Producer end of the write-back interface that the decode stage consumes as its result, destination and write-enable inputs.
- Executes LDR/STR against a variable-latency req/ack data memory.
- Asserts freeze to stall the upstream pipeline while a memory access is pending.
- Registers the MEM/WB values that drive register-file write-back.

---
 rtl/mem_wb_stage_pkg.sv | 19 +
 rtl/mem_wb_reg.sv | 24 ++
 rtl/mem_wb_stage.sv | 139 +++++++++++++
 tb/tb_mem_wb_stage.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_wb_stage_pkg.sv
// Shared constants and types for the MEM/WB stage: FSM encodings, memory window base, bus-error word.
// No logic, so no latency and no backpressure of its own.
// The write-back bundle travels as one packed struct between the stage and its pipeline register.
package mem_wb_stage_pkg;

  localparam logic [1:0]  ST_IDLE          = 2'd0;
  localparam logic [1:0]  ST_WAIT          = 2'd1;
  localparam logic [1:0]  ST_DONE          = 2'd2;

  localparam logic [31:0] MEM_BASE_DEFAULT = 32'd1024;
  localparam logic [31:0] BUS_ERR_VAL      = 32'hDEADBEEF;

  typedef struct packed {
    logic        wb_en;
    logic [3:0]  dest;
    logic [31:0] result;
  } wb_t;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register feeding register-file write-back.
// Latency 1 cycle; while freeze is high it emits a bubble (wb_en=0) and holds dest/result.
// No backpressure of its own: freeze comes from the memory FSM in the parent stage.
module mem_wb_reg
  import mem_wb_stage_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic freeze,
  input  wb_t  wb_d,
  output wb_t  wb_q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_q <= '0;
    end else if (freeze) begin
      wb_q.wb_en <= 1'b0;
    end else begin
      wb_q <= wb_d;
    end
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB stage: runs LDR/STR against a req/ack data memory and registers the write-back values.
// Latency 1 cycle for ALU ops, >=2 cycles for memory ops; freeze stalls upstream until the access is DONE.
// Optional MEM_TIMEOUT_EN aborts a WAIT after TIMEOUT_CYC cycles with a bus-error word and sticky mem_err.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int          ADDR_W   = 16,
  parameter logic [31:0] MEM_BASE = MEM_BASE_DEFAULT
`ifdef MEM_TIMEOUT_EN
  ,
  parameter int          TIMEOUT_CYC = 255
`endif
)
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_en_in,
  input  logic              mem_r_en_in,
  input  logic              mem_w_en_in,
  input  logic [31:0]       alu_result_in,
  input  logic [31:0]       st_val_in,
  input  logic [3:0]        dest_in,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              freeze,
  output logic              write_back_out,
  output logic [3:0]        dest_wb,
  output logic [31:0]       result_wb
`ifdef MEM_TIMEOUT_EN
  ,
  output logic              mem_err
`endif
);

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic [31:0] rdata_q;
  logic        mem_op;
  logic        is_load;
  logic        abort;
  wb_t         wb_d;
  wb_t         wb_q;

  assign mem_op  = mem_r_en_in | mem_w_en_in;
  // A simultaneous read+write is treated as a store.
  assign is_load = mem_r_en_in & ~mem_w_en_in;

  assign mem_req   = ((state == ST_IDLE) & mem_op) | (state == ST_WAIT);
  assign mem_we    = mem_w_en_in;
  assign mem_wdata = st_val_in;
  assign mem_addr  = ADDR_W'((alu_result_in - MEM_BASE) >> 2);
  assign freeze    = mem_op & (state != ST_DONE);

`ifdef MEM_TIMEOUT_EN
  localparam int              CNT_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] wait_cnt;

  // The counter tracks completed WAIT cycles; the last allowed one triggers the abort.
  assign abort = (state == ST_WAIT) & ~mem_ack & (wait_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      if (state == ST_WAIT) begin
        wait_cnt <= wait_cnt + 1'b1;
      end else begin
        wait_cnt <= '0;
      end
      if (abort) begin
        mem_err <= 1'b1;
      end
    end
  end
`else
  assign abort = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (mem_op) begin
          state_nxt = mem_ack ? ST_DONE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mem_ack || abort) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Acks arriving with no request outstanding (e.g. after a reset abandoned one) never reach the latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (mem_req && mem_ack) begin
      rdata_q <= mem_rdata;
    end else if (abort) begin
      rdata_q <= BUS_ERR_VAL;
    end
  end

  assign wb_d.wb_en  = wb_en_in;
  assign wb_d.dest   = dest_in;
  assign wb_d.result = is_load ? rdata_q : alu_result_in;

  mem_wb_reg u_mem_wb_reg (
    .clk    (clk),
    .rst    (rst),
    .freeze (freeze),
    .wb_d   (wb_d),
    .wb_q   (wb_q)
  );

  assign write_back_out = wb_q.wb_en;
  assign dest_wb        = wb_q.dest;
  assign result_wb      = wb_q.result;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: ALU pass-through, loads/stores with varied ack latency, reset mid-access.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_en_in;
  logic        mem_r_en_in;
  logic        mem_w_en_in;
  logic [31:0] alu_result_in;
  logic [31:0] st_val_in;
  logic [3:0]  dest_in;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        freeze;
  logic        write_back_out;
  logic [3:0]  dest_wb;
  logic [31:0] result_wb;
`ifdef MEM_TIMEOUT_EN
  logic        mem_err;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_wb_stage #(
    .ADDR_W   (16),
    .MEM_BASE (32'd1024)
`ifdef MEM_TIMEOUT_EN
    ,
    .TIMEOUT_CYC (4)
`endif
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .wb_en_in       (wb_en_in),
    .mem_r_en_in    (mem_r_en_in),
    .mem_w_en_in    (mem_w_en_in),
    .alu_result_in  (alu_result_in),
    .st_val_in      (st_val_in),
    .dest_in        (dest_in),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_ack        (mem_ack),
    .mem_rdata      (mem_rdata),
    .freeze         (freeze),
    .write_back_out (write_back_out),
    .dest_wb        (dest_wb),
    .result_wb      (result_wb)
`ifdef MEM_TIMEOUT_EN
    ,
    .mem_err        (mem_err)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_in();
    wb_en_in = 0; mem_r_en_in = 0; mem_w_en_in = 0;
    alu_result_in = 0; st_val_in = 0; dest_in = 0;
    mem_ack = 0; mem_rdata = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1;
    idle_in();
    cyc(); cyc();
    #1;
    chk("rst_wb_out", write_back_out, 0);
    chk("rst_dest", dest_wb, 0);
    chk("rst_result", result_wb, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_freeze", freeze, 0);
`ifdef MEM_TIMEOUT_EN
    chk("rst_err", mem_err, 0);
`endif
    rst = 0;

    // ALU pass-through
    wb_en_in = 1; dest_in = 3; alu_result_in = 32'h55;
    #1;
    chk("alu_freeze", freeze, 0);
    chk("alu_req", mem_req, 0);
    cyc();
    idle_in();
    #1;
    chk("alu_wb_out", write_back_out, 1);
    chk("alu_dest", dest_wb, 3);
    chk("alu_result", result_wb, 32'h55);

    // Address wraps below MEM_BASE: (0-1024)>>2 truncated to 16 bits
    chk("addr_wrap", mem_addr, 16'hFF00);

    // LDR with ack after 3 waits
    wb_en_in = 1; mem_r_en_in = 1; dest_in = 5; alu_result_in = 32'd1032;
    #1;
    chk("ldr_req0", mem_req, 1);
    chk("ldr_we", mem_we, 0);
    chk("ldr_addr", mem_addr, 2);
    chk("ldr_freeze0", freeze, 1);
    for (int i = 1; i <= 3; i++) begin
      cyc();
      if (i == 3) begin mem_ack = 1; mem_rdata = 32'hCAFEF00D; end
      #1;
      chk("ldr_wait_freeze", freeze, 1);
      chk("ldr_wait_req", mem_req, 1);
      chk("ldr_bubble", write_back_out, 0);
    end
    cyc();
    mem_ack = 0; mem_rdata = 0;
    #1;
    chk("ldr_done_freeze", freeze, 0);
    chk("ldr_done_req", mem_req, 0);
    chk("ldr_done_wb", write_back_out, 0);
    cyc();
    idle_in();
    #1;
    chk("ldr_wb_out", write_back_out, 1);
    chk("ldr_dest", dest_wb, 5);
    chk("ldr_result", result_wb, 32'hCAFEF00D);
    cyc();
    #1;
    chk("ldr_once", write_back_out, 0);

    // STR with same-cycle ack; result is the address, no write-back
    mem_w_en_in = 1; dest_in = 7; alu_result_in = 32'd1028; st_val_in = 32'h12345678;
    mem_ack = 1; mem_rdata = 32'h99;
    #1;
    chk("str_req", mem_req, 1);
    chk("str_we", mem_we, 1);
    chk("str_addr", mem_addr, 1);
    chk("str_wdata", mem_wdata, 32'h12345678);
    chk("str_freeze", freeze, 1);
    cyc();
    mem_ack = 0;
    #1;
    chk("str_done_freeze", freeze, 0);
    chk("str_done_req", mem_req, 0);
    cyc();
    idle_in();
    #1;
    chk("str_wb_out", write_back_out, 0);
    chk("str_dest", dest_wb, 7);
    chk("str_result", result_wb, 32'd1028);

    // Back-to-back loads: 0 waits then 1 wait
    wb_en_in = 1; mem_r_en_in = 1; dest_in = 1; alu_result_in = 32'd1040;
    mem_ack = 1; mem_rdata = 32'hAAAA0001;
    #1;
    chk("b2b1_addr", mem_addr, 4);
    chk("b2b1_freeze", freeze, 1);
    cyc();
    mem_ack = 0; mem_rdata = 0;
    #1;
    chk("b2b1_done_req", mem_req, 0);
    chk("b2b1_done_freeze", freeze, 0);
    cyc();
    dest_in = 2; alu_result_in = 32'd1059;
    #1;
    chk("b2b1_wb_out", write_back_out, 1);
    chk("b2b1_dest", dest_wb, 1);
    chk("b2b1_result", result_wb, 32'hAAAA0001);
    chk("b2b2_req", mem_req, 1);
    chk("b2b2_addr", mem_addr, 8);
    chk("b2b2_freeze", freeze, 1);
    cyc();
    mem_ack = 1; mem_rdata = 32'hBBBB0002;
    #1;
    chk("b2b2_bubble", write_back_out, 0);
    chk("b2b2_wait_freeze", freeze, 1);
    cyc();
    mem_ack = 0; mem_rdata = 0;
    #1;
    chk("b2b2_done_req", mem_req, 0);
    chk("b2b2_done_freeze", freeze, 0);
    cyc();
    idle_in();
    #1;
    chk("b2b2_wb_out", write_back_out, 1);
    chk("b2b2_dest", dest_wb, 2);
    chk("b2b2_result", result_wb, 32'hBBBB0002);

    // Read+write together: store wins, result is the ALU value
    wb_en_in = 1; mem_r_en_in = 1; mem_w_en_in = 1; dest_in = 9; alu_result_in = 32'd1036;
    mem_ack = 1; mem_rdata = 32'h5555;
    #1;
    chk("rw_we", mem_we, 1);
    chk("rw_addr", mem_addr, 3);
    cyc();
    mem_ack = 0;
    cyc();
    idle_in();
    #1;
    chk("rw_wb_out", write_back_out, 1);
    chk("rw_result", result_wb, 32'd1036);

    // Reset held 2 cycles mid-WAIT, then a late ack
    wb_en_in = 1; mem_r_en_in = 1; dest_in = 6; alu_result_in = 32'd1032;
    cyc();
    #1;
    chk("rstw_req_wait", mem_req, 1);
    rst = 1;
    idle_in();
    cyc(); cyc();
    rst = 0;
    #1;
    chk("rstw_req", mem_req, 0);
    chk("rstw_wb_out", write_back_out, 0);
    chk("rstw_freeze", freeze, 0);
    cyc();
    mem_ack = 1; mem_rdata = 32'h77;
    cyc();
    mem_ack = 0; mem_rdata = 0;
    #1;
    chk("late_ack_req", mem_req, 0);
    chk("late_ack_wb_out", write_back_out, 0);
    cyc();
    #1;
    chk("late_ack_wb_out2", write_back_out, 0);
    chk("late_ack_result", result_wb, 0);

`ifdef MEM_TIMEOUT_EN
    // No ack: abort after 4 WAIT cycles
    wb_en_in = 1; mem_r_en_in = 1; dest_in = 4; alu_result_in = 32'd1032;
    for (int i = 1; i <= 4; i++) begin
      cyc();
      #1;
      chk("to_wait_freeze", freeze, 1);
      chk("to_wait_err", mem_err, 0);
    end
    cyc();
    #1;
    chk("to_done_freeze", freeze, 0);
    chk("to_err", mem_err, 1);
    cyc();
    idle_in();
    #1;
    chk("to_wb_out", write_back_out, 1);
    chk("to_result", result_wb, 32'hDEADBEEF);
    cyc();
    #1;
    chk("to_err_sticky", mem_err, 1);
    rst = 1;
    cyc();
    rst = 0;
    #1;
    chk("to_err_cleared", mem_err, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
